// File: rtl/pla_in5_eval_arbiter.sv
// Round-robin arbiter that time-shares one combinational pla__in5 evaluator.
// A granted requester's input vector is registered onto the PLA inputs and held
// for EVAL_CYCLES cycles. The PLA result is then captured and returned with the
// requester id on a valid/ready response channel.
module pla_in5_eval_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IN_W        = 24,
    parameter int unsigned OUT_W       = 14,
    parameter int unsigned EVAL_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*IN_W-1:0]    req_data,
    output logic [IN_W-1:0]            pla_x,
    input  logic [OUT_W-1:0]           pla_z,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [OUT_W-1:0]           rsp_data,
    output logic                       busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [NUM_REQ-1:0] grant_oh;
    logic              grant_any;
    logic [CNT_W-1:0]  cnt;
    logic [IN_W-1:0]   req_vec [NUM_REQ];

    // Unpack the flat request bus into one vector per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign req_vec[i] = req_data[i*IN_W +: IN_W];
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Accept strobe only exists in IDLE; forced low while reset is held.
    assign req_ready = (state == IDLE && !rst) ? grant_oh : '0;

    // Sequencer: grant, hold PLA inputs for the settle window, then respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pla_x      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        pla_x      <= req_vec[grant_idx];
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        cnt        <= CNT_W'(EVAL_CYCLES - 1);
                        busy       <= 1'b1;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt == '0) begin
                        rsp_data  <= pla_z;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // pla_x is left untouched so the PLA stays quiet while idle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pla_in5_eval_arbiter.sv
// Self-checking bench for pla_in5_eval_arbiter with a transaction-level model.
module tb_pla_in5_eval_arbiter;

    localparam int N   = 4;
    localparam int IW  = 24;
    localparam int OW  = 14;
    localparam int EC  = 2;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*IW-1:0] req_data;
    logic [IW-1:0]   pla_x;
    logic [OW-1:0]   pla_z;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [OW-1:0]   rsp_data;
    logic            busy;

    logic [IW-1:0]   rdata [N];

    int checks = 0;
    int errors = 0;
    int granted = -1;

    // model of the arbiter at transaction level
    int            m_last;
    bit            m_busy;
    bit            m_rv;
    int            m_age;
    int            m_id;
    logic [IW-1:0] m_x;
    logic [OW-1:0] m_data;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_data[gi*IW +: IW] = rdata[gi];
    end

    // Stand-in for the shared PLA: known rows from the truth table, a scramble elsewhere.
    function automatic logic [OW-1:0] pla_fn(input logic [IW-1:0] x);
        logic [IW-1:0] t;
        case (x)
            24'h002201: return 14'h0846;
            24'h008000: return 14'h2000;
            24'h041000: return 14'h00B0;
            default: begin
                t = x ^ (x >> 10) ^ (x << 5) ^ 24'h5A3C96;
                return t[OW-1:0];
            end
        endcase
    endfunction

    assign pla_z = pla_fn(pla_x);

    pla_in5_eval_arbiter #(
        .NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .EVAL_CYCLES(EC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .pla_x(pla_x), .pla_z(pla_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = v >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_busy = 1'b0;
        m_rv   = 1'b0;
        m_age  = 0;
        m_id   = 0;
        m_x    = '0;
        m_data = '0;
    endtask

    // One clock: compare at negedge, advance the model just after posedge.
    task automatic tick();
        logic [N-1:0]   want_rdy;
        logic [IDW-1:0] gsel;
        int g;
        bit rst_s;
        bit rr_s;
        @(negedge clk);
        if (rst) model_reset();
        g = m_busy ? -1 : rr_pick(req_valid, m_last);
        want_rdy = '0;
        if (!rst && g >= 0) want_rdy = N'(1) << g;
        chk("req_ready", 32'(req_ready), 32'(want_rdy));
        chk("pla_x",     32'(pla_x),     32'(m_x));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        chk("busy",      32'(busy),      32'(m_busy));
        rst_s = rst;
        rr_s  = rsp_ready;
        @(posedge clk);
        #1;
        granted = -1;
        if (rst_s) begin
            model_reset();
        end else if (!m_busy) begin
            if (g >= 0) begin
                gsel    = IDW'(g);
                m_x     = rdata[gsel];
                m_id    = g;
                m_last  = g;
                m_busy  = 1'b1;
                m_age   = 0;
                granted = g;
            end
        end else if (!m_rv) begin
            m_age++;
            if (m_age == EC) begin
                m_data = pla_fn(m_x);
                m_rv   = 1'b1;
            end
        end else if (rr_s) begin
            m_rv   = 1'b0;
            m_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_one(input logic [IDW-1:0] id, input logic [IW-1:0] d, input logic [OW-1:0] lit);
        int n;
        rdata[id] = d;
        req_valid = N'(1) << id;
        rsp_ready = 1'b1;
        #1;
        chk("accept_ready", 32'(req_ready), 32'(N'(1) << id));
        tick();
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(EC));
        chk("lit_rsp_id", 32'(rsp_id), 32'(id));
        chk("lit_rsp_data", 32'(rsp_data), 32'(lit));
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("drain_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        int order [5];
        int want_order [5];
        int nq;
        int n;
        logic [N-1:0] pend;
        logic [IW-1:0] d2;
        logic [IDW-1:0] ii;

        want_order = '{0, 1, 2, 3, 0};
        model_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ii = IDW'(i);
            rdata[ii] = '0;
        end
        tick();
        chk("reset_pla_x", 32'(pla_x), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        // directed single transactions with known PLA rows
        do_one(2'd0, 24'h002201, 14'h0846);
        do_one(2'd2, 24'h008000, 14'h2000);
        do_one(2'd1, 24'h041000, 14'h00B0);

        // all requesters persistent: rotation from a fresh pointer
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            ii = IDW'(i);
            rdata[ii] = IW'($urandom);
        end
        for (int i = 0; i < 5; i++) order[i] = -1;
        req_valid = '1;
        nq = 0;
        n  = 0;
        while (nq < 5 && n < 60) begin
            tick();
            if (granted >= 0) begin
                order[nq] = granted;
                nq++;
            end
            n++;
        end
        req_valid = '0;
        chk("grant_count", 32'(nq), 32'(5));
        for (int i = 0; i < 5; i++) chk("grant_order", 32'(order[i]), 32'(want_order[i]));
        drain();

        // response stall with a second requester waiting
        d2 = IW'($urandom);
        rdata[2] = d2;
        rdata[3] = IW'($urandom);
        req_valid = 4'b1100;
        rsp_ready = 1'b0;
        tick();
        chk("stall_grant", 32'(granted), 32'(2));
        req_valid = 4'b1000;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", 32'(req_ready), 32'(0));
            chk("stall_valid", 32'(rsp_valid), 32'(1));
            chk("stall_id", 32'(rsp_id), 32'(2));
            chk("stall_data", 32'(rsp_data), 32'(pla_fn(d2)));
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        chk("regrant_ready", 32'(req_ready), 32'(4'b1000));
        tick();
        chk("regrant_id", 32'(granted), 32'(3));
        req_valid = '0;
        tick();

        // reset while requester 3 is in its settle window
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_pla_x", 32'(pla_x), 32'(0));
        chk("abort_rsp_id", 32'(rsp_id), 32'(0));
        req_valid = 4'b1001;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("prio_after_rst", 32'(req_ready), 32'(4'b0001));
        tick();
        chk("prio_grant", 32'(granted), 32'(0));
        req_valid = '0;
        drain();

        // randomized traffic with withdrawals, stalls and occasional resets
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                ii = IDW'(i);
                if (!pend[ii] && $urandom_range(0, 3) == 0) begin
                    pend[ii]  = 1'b1;
                    rdata[ii] = IW'($urandom);
                end else if (pend[ii] && $urandom_range(0, 19) == 0) begin
                    pend[ii] = 1'b0;
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
            if (granted >= 0) pend = pend & ~(N'(1) << granted);
        end
        rst = 1'b0;
        req_valid = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/pla_in5_eval_arbiter.md
Name: pla_in5_eval_arbiter

Overview:
- Sequences and shares one combinational pla__in5 evaluator (24 inputs x00..x23, 14 outputs z00..z13) among NUM_REQ requesters.
- Grants requesters round-robin and registers the granted 24-bit input vector onto the shared PLA inputs.
- Waits a fixed settle window, then captures the 14-bit result and returns it with the requester's id over a valid/ready response channel.
- Sits between requesting control units and the shared PLA instance; it is the only driver of the PLA inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_W, 24, PLA input width; bit k drives xNN with NN = k.
- OUT_W, 14, PLA output width; bit k is zNN with NN = k.
- EVAL_CYCLES, 2, cycles the PLA inputs are held before its outputs are sampled (>= 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit set.
- req_data  in  NUM_REQ*IN_W  requester i vector at [i*IN_W +: IN_W].
- pla_x  out  IN_W  registered drive to the shared PLA inputs x00..x23.
- pla_z  in  OUT_W  shared PLA outputs z00..z13.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_data  out  OUT_W  captured PLA result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state = IDLE, pla_x = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, req_ready = 0, busy = 0. The round-robin pointer is set so that requester 0 has top priority.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - req_ready = one-hot grant g, combinational from req_valid.
  - g is the first requester with valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready is all-zero when no valid is set.
  - On the clock edge with any valid set: pla_x <= req_data[g], rsp_id <= g, last_grant <= g, cnt <= EVAL_CYCLES-1, go to EVAL.
- EVAL:
  - pla_x is held stable and cnt decrements each cycle.
  - On the cycle where cnt == 0: rsp_data <= pla_z, rsp_valid <= 1, go to RESP.
  - EVAL therefore lasts exactly EVAL_CYCLES cycles.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in that same cycle.
- req_ready is 0 in EVAL and RESP. New requests are only sampled in IDLE.
- Minimum request-to-request spacing is EVAL_CYCLES+2 cycles.
- Latency: accept edge to rsp_valid high is EVAL_CYCLES cycles.
- Requesters must hold req_valid and req_data until their req_ready. Withdrawing valid before a grant is legal and produces no transaction.
- pla_x keeps the last granted vector after the response, so the PLA is not toggled while idle.
- Fairness: every continuously asserting requester is granted within NUM_REQ transactions. There is no starvation under persistent requests.
- Reset asserted mid-EVAL or mid-RESP aborts the transaction. No response is issued and the pointer returns to its reset value.
- Response stall: the arbiter remains in RESP indefinitely while rsp_ready = 0. Other requesters wait.

Test Plan:
- Reset, then requester 0 sends req_data = 0x002201 (x00, x09, x13) with rsp_ready = 1.
  - req_ready = 0001 in the accept cycle.
  - rsp_valid rises 2 cycles later with rsp_id = 0 and rsp_data = 0x846 (z01, z02, z06, z11).
- Requester 2 sends 0x008000 (x15 only) -> rsp_id = 2, rsp_data = 0x2000 (z13).
- Requester 1 sends 0x041000 (x12, x18) -> rsp_data = 0x0B0 (z04, z05, z07).
- All 4 requesters hold valid continuously -> grant order is 0, 1, 2, 3, 0; each req_ready is a single-cycle pulse; busy is high across each transaction.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant and req_ready stays 0000. Release -> the next grant occurs one cycle after the handshake.
- Assert rst during EVAL -> all outputs return to 0 immediately with no rsp_valid. After release, requester 0 has priority even if requester 3 was mid-transaction.
